// File: rtl/alu_rr_arbiter.sv
// Round-robin front-end sharing one ALU between two requesters, one operation in flight.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_rr_arbiter #(
    parameter int unsigned DW    = 8,
    parameter int unsigned OPW   = 4
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [DW-1:0]    req_a0,
    input  logic [DW-1:0]    req_b0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [DW-1:0]    req_a1,
    input  logic [DW-1:0]    req_b1,
    input  logic [OPW-1:0]   req_op1,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [DW-1:0]    alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [DW-1:0]    rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           rr_last_q, rr_last_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_result_q, rsp_result_d;
    logic           rsp_zero_q, rsp_zero_d;
    logic           rsp_carry_q, rsp_carry_d;
    logic           busy_q, busy_d;
    logic           grant_vld;
    logic           grant_id;

    // Next-state, grant selection and capture logic
    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        grant_vld    = 1'b0;
        grant_id     = 1'b0;
        req_ready    = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    grant_vld = 1'b1;
                    grant_id  = (req_valid == 2'b11) ? ~rr_last_q : req_valid[1];
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    alu_a_d   = grant_id ? req_a1  : req_a0;
                    alu_b_d   = grant_id ? req_b1  : req_b0;
                    alu_op_d  = grant_id ? req_op1 : req_op0;
                    rsp_id_d  = grant_id;
                    rr_last_d = grant_id;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Carry is only meaningful for ADD (0) and SUB (1)
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_carry_d  = alu_carry & (alu_op_q[OPW-1:1] == '0);
                rsp_valid_d  = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Saturating grant counters; clear has priority
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (stats_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (grant_vld) begin
            if (!grant_id && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
            if (grant_id  && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_last_q    <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model and a behavioural ALU.
module tb_alu_rr_arbiter;
    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;
`ifdef ALU_ARB_STATS_EN
    localparam int unsigned CW  = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     req_valid, req_ready;
    logic [DW-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [OPW-1:0] req_op0, req_op1;
    logic [DW-1:0]  alu_a, alu_b, alu_result;
    logic [OPW-1:0] alu_opcode;
    logic           alu_zero, alu_carry;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry, busy;
    logic [DW-1:0]  rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic           stats_clr = 1'b0;
    logic [CW-1:0]  grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .DW(DW), .OPW(OPW)
`ifdef ALU_ARB_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_ARB_STATS_EN
        .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    // Behavioural ALU: returns {carry, zero, result}
    function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] w;
        case (op)
            4'd0:    w = {1'b0, a} + {1'b0, b};
            4'd1:    w = {1'b0, a} - {1'b0, b};
            4'd2:    w = {1'b0, a & b};
            4'd3:    w = {1'b0, a | b};
            4'd4:    w = {1'b0, a ^ b};
            4'd5:    w = {1'b0, ~a};
            4'd6:    w = {a, 1'b0};
            4'd7:    w = {a[0], 1'b0, a[7:1]};
            4'd8:    w = {1'b0, a};
            4'd9:    w = {1'b0, b};
            default: w = 9'd0;
        endcase
        return {w[8], (w[7:0] == 8'd0), w[7:0]};
    endfunction

    assign {alu_carry, alu_zero, alu_result} = alu_f(alu_a, alu_b, alu_opcode);

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pending requests held by the requester front-ends
    bit             pv[2];
    logic [7:0]     pa[2], pb[2];
    logic [3:0]     po[2];
    bit             auto_fill = 0;

    // Reference model state (transaction level)
    bit             m_inflight, m_valid, m_rr_last;
    int             m_cnt;
    logic [7:0]     m_a, m_b, m_res;
    logic [3:0]     m_op;
    logic           m_id, m_zero, m_carry;
    int             m_gcnt[2];
    logic [10:0]    rsp_log[$];

    task automatic model_reset();
        m_inflight = 0; m_valid = 0; m_rr_last = 1; m_cnt = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0;
        m_id = 0; m_zero = 0; m_carry = 0;
        m_gcnt[0] = 0; m_gcnt[1] = 0;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        pv[i] = 1; pa[i] = a; pb[i] = b; po[i] = op;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        pv[0] = 0; pv[1] = 0;
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_zero, rsp_carry, rsp_result}), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
`ifdef ALU_ARB_STATS_EN
        check("rst_cnt", 32'({grant_cnt0, grant_cnt1}), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus, output checking and model update
    task automatic step(input bit rdy);
        int         g;
        bit         hs;
        logic [1:0] er;
        logic [9:0] f;
        @(negedge clk);
        if (auto_fill)
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
        req_valid = {pv[1], pv[0]};
        req_a0 = pa[0]; req_b0 = pb[0]; req_op0 = po[0];
        req_a1 = pa[1]; req_b1 = pb[1]; req_op1 = po[1];
        rsp_ready = rdy;
        #1;
        g = -1;
        if (!m_inflight) begin
            if (pv[0] && pv[1]) g = m_rr_last ? 0 : 1;
            else if (pv[0])     g = 0;
            else if (pv[1])     g = 1;
        end
        er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        check("req_ready", 32'(req_ready), 32'(er));
        check("busy", 32'(busy), 32'(m_inflight));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_result", 32'(rsp_result), 32'(m_res));
        check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        check("alu_regs", 32'({alu_a, alu_b, alu_opcode}), 32'({m_a, m_b, m_op}));
`ifdef ALU_ARB_STATS_EN
        check("grant_cnt0", 32'(grant_cnt0), 32'(m_gcnt[0]));
        check("grant_cnt1", 32'(grant_cnt1), 32'(m_gcnt[1]));
`endif
        hs = m_valid && rdy;
        @(posedge clk);
        if (hs) begin
            rsp_log.push_back({m_id, m_carry, m_zero, m_res});
            m_valid = 0;
            m_inflight = 0;
        end
        if (m_cnt != 0) begin
            f = alu_f(m_a, m_b, m_op);
            m_res = f[7:0];
            m_zero = f[8];
            m_carry = f[9] && (m_op <= 4'd1);
            m_valid = 1;
            m_cnt = 0;
        end
        if (g >= 0) begin
            m_inflight = 1;
            m_cnt = 1;
            m_a = pa[g]; m_b = pb[g]; m_op = po[g];
            m_id = 1'(g);
            m_rr_last = (g == 1);
            pv[g] = 0;
`ifdef ALU_ARB_STATS_EN
            if (m_gcnt[g] < (1 << CW) - 1) m_gcnt[g]++;
`endif
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [10:0] exp);
        check({tag, "_present"}, 32'(rsp_log.size() > idx), 32'd1);
        if (rsp_log.size() > idx) check(tag, 32'(rsp_log[idx]), 32'(exp));
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        {req_a0, req_b0, req_op0, req_a1, req_b1, req_op1} = '0;
        pv[0] = 0; pv[1] = 0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; po[0] = '0; po[1] = '0;
        model_reset();

        // Single requester ADD
        apply_reset();
        base = rsp_log.size();
        set_req(0, 8'h0F, 8'h01, 4'd0);
        repeat (5) step(1);
        check_log("t1", base, {1'b0, 1'b0, 1'b0, 8'h10});

        // Both valid out of reset: requester 0 first
        apply_reset();
        base = rsp_log.size();
        set_req(0, 8'hFF, 8'h01, 4'd0);
        set_req(1, 8'h05, 8'h05, 4'd1);
        repeat (8) step(1);
        check_log("t2_first", base, {1'b0, 1'b1, 1'b1, 8'h00});
        check_log("t2_second", base + 1, {1'b1, 1'b0, 1'b1, 8'h00});

        // Continuous contention alternates
        base = rsp_log.size();
        for (int k = 0; k < 6; k++) begin
            if (!pv[0]) set_req(0, 8'(k), 8'h01, 4'd0);
            if (!pv[1]) set_req(1, 8'(k), 8'h02, 4'd3);
            repeat (3) step(1);
        end
        for (int k = 0; k < 6; k++)
            if (rsp_log.size() > base + k) check("t3_alt", 32'(rsp_log[base + k][10]), 32'(k % 2));

        // Carry masking
        base = rsp_log.size();
        set_req(0, 8'hFF, 8'hFF, 4'd0);
        repeat (4) step(1);
        set_req(0, 8'hF0, 8'h0F, 4'd2);
        repeat (4) step(1);
        check_log("t5_add", base, {1'b0, 1'b1, 1'b0, 8'hFE});
        check_log("t5_and", base + 1, {1'b0, 1'b0, 1'b1, 8'h00});

        // Backpressure: model checks stability, req_ready and busy each cycle
        set_req(1, 8'h33, 8'h11, 4'd1);
        set_req(0, 8'h44, 8'h22, 4'd4);
        repeat (2) step(1);
        repeat (5) step(0);
        repeat (6) step(1);

        // Reset during RESP, then requester 0 wins again
        set_req(0, 8'h12, 8'h34, 4'd0);
        set_req(1, 8'h56, 8'h78, 4'd1);
        step(1);
        step(1);
        step(0);
        apply_reset();
        base = rsp_log.size();
        set_req(0, 8'h01, 8'h02, 4'd0);
        set_req(1, 8'h03, 8'h04, 4'd0);
        repeat (4) step(1);
        check_log("t6_first", base, {1'b0, 1'b0, 1'b0, 8'h03});

        // Random traffic with random backpressure and occasional reset
        auto_fill = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 750 == 749) apply_reset();
            step($urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
